// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for decode_stage.
// master = the decode stage, slave = the fetch/execute environment around it.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [3:0]      alu_ctrl;
  logic            op1_sel;
  logic            w_en;
  logic            mw_en;
  logic            maddr_sel;
  logic [2:0]      dmem_ctrl;
  logic [2:0]      branch_ctrl;
  logic            jump_en;
  logic [1:0]      jump_type;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] jump_offset;
  logic            illegal;

  modport master (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, alu_ctrl, op1_sel,
           w_en, mw_en, maddr_sel, dmem_ctrl, branch_ctrl, jump_en,
           jump_type, imm, jump_offset, illegal
  );

  modport slave (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, alu_ctrl, op1_sel,
           w_en, mw_en, maddr_sel, dmem_ctrl, branch_ctrl, jump_en,
           jump_type, imm, jump_offset, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with load-use bubble insertion and flush.
// Define DECODE_ILLEGAL_TRAP_EN to flag undecodable instructions on the illegal output.
module decode_stage #(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_CUSTOM = 7'b0001011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_ctrl;
    logic            op1_sel;
    logic            w_en;
    logic            mw_en;
    logic            maddr_sel;
    logic [2:0]      dmem_ctrl;
    logic [2:0]      branch_ctrl;
    logic            jump_en;
    logic [1:0]      jump_type;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jump_offset;
    logic            illegal;
  } bundle_t;

  typedef enum logic {RUN, BUBBLE} state_t;

  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r, is_i, is_ld, is_st, is_br, is_cu, is_lui, is_auipc, is_jal, is_jalr;
  logic        use_rs1, use_rs2, use_rd;
  logic signed [31:0] imm_i, imm_s, imm_u, off_b, off_j;
  bundle_t     dec;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_cu    = (opcode == OP_CUSTOM);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  assign use_rs1 = is_r | is_i | is_ld | is_st | is_br | is_cu | is_jalr;
  assign use_rs2 = is_r | is_st | is_br;
  assign use_rd  = is_r | is_i | is_ld | is_lui | is_auipc | is_jal | is_jalr;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u = {inst[31:12], 12'b0};
  assign off_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign off_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Unrecognised opcodes match no class, so every field naturally stays zero.
  always_comb begin
    dec             = '0;
    dec.rs1         = use_rs1 ? inst[19:15] : 5'd0;
    dec.rs2         = use_rs2 ? inst[24:20] : 5'd0;
    dec.rd          = use_rd  ? inst[11:7]  : 5'd0;
    dec.op1_sel     = is_i | is_ld | is_st | is_lui | is_auipc | is_jalr;
    dec.w_en        = use_rd && (inst[11:7] != 5'd0);
    dec.mw_en       = is_st;
    dec.maddr_sel   = is_ld;
    dec.dmem_ctrl   = (is_ld | is_st) ? funct3 : 3'd0;
    dec.branch_ctrl = is_br ? funct3 : 3'd0;
    dec.jump_en     = is_br | is_jal | is_jalr;
    if (is_r)
      dec.alu_ctrl = {inst[30], funct3};
    else if (is_i)
      dec.alu_ctrl = {inst[30] && (funct3 == 3'b101), funct3};
    if (is_br)        dec.jump_type = 2'b01;
    else if (is_jal)  dec.jump_type = 2'b10;
    else if (is_jalr) dec.jump_type = 2'b11;
    if (is_i | is_ld | is_jalr)  dec.imm = sext(imm_i);
    else if (is_st)              dec.imm = sext(imm_s);
    else if (is_lui | is_auipc)  dec.imm = sext(imm_u);
    if (is_br)       dec.jump_offset = sext(off_b);
    else if (is_jal) dec.jump_offset = sext(off_j);
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal = !(use_rs1 | use_rd | is_st | is_br);
`endif
  end

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       track_vld;
  logic [4:0] track_rd;
  logic       hazard, slot_free, accept, bubble_start;
  logic       vld_p1;
  bundle_t    bundle_p1;
  logic [XLEN-1:0] pc_p1;

  // Unused source fields decode to 0 and track_rd is never 0, so comparing both is safe.
  assign hazard = (LOAD_USE_BUBBLES > 0) && track_vld && bus.in_valid &&
                  ((dec.rs1 == track_rd) || (dec.rs2 == track_rd));
  assign slot_free    = !vld_p1 || bus.out_ready;
  assign bus.in_ready = slot_free && !bus.flush && (state == RUN) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bubble_start = (state == RUN) && hazard && slot_free;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (bus.flush) begin
      state_n = RUN;
      cnt_n   = 2'd0;
    end else begin
      case (state)
        RUN: if (bubble_start) begin
          state_n = BUBBLE;
          cnt_n   = 2'(LOAD_USE_BUBBLES);
        end
        BUBBLE: if (cnt <= 2'd1) begin
          state_n = RUN;
          cnt_n   = 2'd0;
        end else begin
          cnt_n = cnt - 2'd1;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush || bubble_start) begin
      track_vld <= 1'b0;
      track_rd  <= 5'd0;
    end else if (accept) begin
      track_vld <= is_ld && (inst[11:7] != 5'd0);
      track_rd  <= inst[11:7];
    end
  end

  // ---- stage p1: decoded bundle register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
      pc_p1     <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (slot_free) begin
      vld_p1 <= accept;
      if (accept) begin
        bundle_p1 <= dec;
        pc_p1     <= bus.in_pc;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_pc      = pc_p1;
  assign bus.rs1         = bundle_p1.rs1;
  assign bus.rs2         = bundle_p1.rs2;
  assign bus.rd          = bundle_p1.rd;
  assign bus.alu_ctrl    = bundle_p1.alu_ctrl;
  assign bus.op1_sel     = bundle_p1.op1_sel;
  assign bus.w_en        = bundle_p1.w_en;
  assign bus.mw_en       = bundle_p1.mw_en;
  assign bus.maddr_sel   = bundle_p1.maddr_sel;
  assign bus.dmem_ctrl   = bundle_p1.dmem_ctrl;
  assign bus.branch_ctrl = bundle_p1.branch_ctrl;
  assign bus.jump_en     = bundle_p1.jump_en;
  assign bus.jump_type   = bundle_p1.jump_type;
  assign bus.imm         = bundle_p1.imm;
  assign bus.jump_offset = bundle_p1.jump_offset;
  assign bus.illegal     = bundle_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes hand-computed bundles, monitor pops on each transfer.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        op1, w_en, mw_en, maddr;
    logic [2:0]  dmem, br;
    logic        jen;
    logic [1:0]  jtype;
    logic [31:0] imm, joff;
    logic        ill;
  } bun_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic cur_ordy = 1'b1;
  logic [31:0] pc_ctr = 32'h0000_1000;
  bun_t exp_q[$];
  bun_t e;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32), .LOAD_USE_BUBBLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic bun_t act();
    bun_t a;
    a.pc = bus.out_pc;  a.rs1 = bus.rs1;  a.rs2 = bus.rs2;  a.rd = bus.rd;
    a.alu = bus.alu_ctrl;  a.op1 = bus.op1_sel;  a.w_en = bus.w_en;
    a.mw_en = bus.mw_en;  a.maddr = bus.maddr_sel;  a.dmem = bus.dmem_ctrl;
    a.br = bus.branch_ctrl;  a.jen = bus.jump_en;  a.jtype = bus.jump_type;
    a.imm = bus.imm;  a.joff = bus.jump_offset;  a.ill = bus.illegal;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Offer one instruction; expected bundle is queued on the cycle it is accepted.
  task automatic send(input logic [31:0] inst, input bun_t ex);
    bit ok;
    ok = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_pc     = pc_ctr;
    bus.out_ready = cur_ordy;
    ex.pc = pc_ctr;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(ex);
        ok = 1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    pc_ctr += 4;
    total++;
    if (!ok) begin
      bad++;
      bus.in_valid = 1'b0;
      $display("FAIL accept_timeout inst=%h got in_ready=0 want 1", inst);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = cur_ordy;
    end
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    bun_t a, x;
    #2;
    if (bus.out_valid && bus.out_ready) begin
      a = act();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bundle got=%h want=none", a);
      end else begin
        x = exp_q.pop_front();
        if (a !== x) begin
          bad++;
          $display("FAIL bundle pc=%h got=%h want=%h", x.pc, a, x);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.in_inst = 32'h0;
    bus.in_pc = 32'h0;  bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset_valid_ready", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    check("reset_fields", 64'(act() != '0), 64'd0);

    // ALU, immediate, memory, branch and jump classes
    e = '0; e.rs1 = 1; e.rs2 = 2; e.rd = 3; e.w_en = 1;                    send(32'h002081B3, e);
    e = '0; e.rs1 = 1; e.rs2 = 2; e.rd = 4; e.w_en = 1; e.alu = 4'b1000;   send(32'h40208233, e);
    e = '0; e.rs1 = 1; e.rd = 5; e.w_en = 1; e.op1 = 1; e.imm = 32'hFFFF_FFFF; send(32'hFFF08293, e);
    e = '0; e.rs1 = 1; e.rd = 6; e.w_en = 1; e.op1 = 1; e.alu = 4'b1101; e.imm = 32'h403; send(32'h4030D313, e);
    e = '0; e.rs1 = 1; e.rs2 = 2; e.op1 = 1; e.mw_en = 1; e.dmem = 3'b010; e.imm = 32'd12; send(32'h0020A623, e);
    e = '0; e.rs1 = 1; e.rs2 = 2; e.jen = 1; e.jtype = 2'b01; e.joff = 32'hFFFF_FFF8; send(32'hFE208CE3, e);
    e = '0; e.rd = 7; e.w_en = 1; e.op1 = 1; e.imm = 32'h1234_5000;       send(32'h123453B7, e);
    e = '0; e.rd = 8; e.w_en = 1; e.op1 = 1; e.imm = 32'h8000_0000;       send(32'h80000417, e);
    e = '0; e.rd = 1; e.w_en = 1; e.jen = 1; e.jtype = 2'b10; e.joff = 32'hFFFF_FFFC; send(32'hFFDFF0EF, e);
    e = '0; e.rs1 = 1; e.op1 = 1; e.jen = 1; e.jtype = 2'b11;             send(32'h00008067, e);
    e = '0; e.rs1 = 1;                                                     send(32'h0000828B, e);
    e = '0; e.rs1 = 1; e.rs2 = 2;                                          send(32'h00208033, e);
    e = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    e.ill = 1;
`endif
    send(32'h0000_0000, e);
    send(32'h0020_8030, e);

    // load-use bubble: LW x5 then ADD x6,x5,x0
    idle(3);
    e = '0; e.rs1 = 1; e.rd = 5; e.w_en = 1; e.op1 = 1; e.maddr = 1; e.dmem = 3'b010; e.imm = 32'd8;
    send(32'h0080A283, e);
    @(negedge clk);
    bus.in_valid = 1'b1;  bus.in_inst = 32'h00028333;  bus.in_pc = pc_ctr;
    #1 check("hazard_stall_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    #1 check("bubble_cycle", {62'd0, bus.out_valid, bus.in_ready}, 64'd0);
    e = '0; e.rs1 = 5; e.rd = 6; e.w_en = 1;
    send(32'h00028333, e);

    // back-pressure hold, then gap-free release
    idle(3);
    cur_ordy = 1'b0;
    e = '0; e.rs1 = 1; e.rd = 5; e.w_en = 1; e.op1 = 1; e.imm = 32'hFFFF_FFFF;
    send(32'hFFF08293, e);
    @(negedge clk);
    bus.in_valid = 1'b1;  bus.in_inst = 32'h002081B3;  bus.in_pc = pc_ctr;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold", {bus.out_valid, bus.in_ready, 25'd0, bus.rd, bus.imm},
                       {1'b1, 1'b0, 25'd0, 5'd5, 32'hFFFF_FFFF});
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    cur_ordy = 1'b1;
    e = '0; e.rs1 = 1; e.rs2 = 2; e.rd = 3; e.w_en = 1;
    send(32'h002081B3, e);
    @(negedge clk);
    #1 check("no_gap", {58'd0, bus.out_valid, bus.rd}, {58'd0, 1'b1, 5'd3});

    // flush during bubble
    idle(3);
    e = '0; e.rs1 = 1; e.rd = 5; e.w_en = 1; e.op1 = 1; e.maddr = 1; e.dmem = 3'b010; e.imm = 32'd8;
    send(32'h0080A283, e);
    @(negedge clk);
    bus.in_valid = 1'b1;  bus.in_inst = 32'h00028333;  bus.in_pc = pc_ctr;
    @(negedge clk);
    bus.flush = 1'b1;
    #1 check("flush_blocks_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1 check("after_flush_bubble", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b0;

    // flush of a held bundle; incoming instruction must be dropped too
    idle(2);
    cur_ordy = 1'b0;
    e = '0; e.rs1 = 1; e.rd = 5; e.w_en = 1; e.op1 = 1; e.imm = 32'hFFFF_FFFF;
    send(32'hFFF08293, e);
    @(negedge clk);
    bus.flush = 1'b1;  bus.in_valid = 1'b1;  bus.in_inst = 32'h002081B3;
    #1 check("flush_held_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;  bus.in_valid = 1'b0;
    void'(exp_q.pop_back());
    #1 check("after_flush_held", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    cur_ordy = 1'b1;
    idle(5);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage with a valid/ready handshake on both sides.
- Decodes R, I-ALU, load, store, branch, custom (0001011), LUI, AUIPC, JAL and JALR.
- Inserts load-use bubbles and supports a pipeline flush.
- Sits between fetch (in_*) and execute (out_*).

Parameters:
- XLEN, 32, width of immediates, offsets and PC.
- LOAD_USE_BUBBLES, 1, bubble cycles after a load whose rd is read by the next instruction; legal 0..3, 0 disables hazard logic.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  registered PC
- rs1, rs2, rd  out  5 each  register indices
- alu_ctrl  out  4  ALU op
- op1_sel  out  1  1 = second operand is imm
- w_en, mw_en, maddr_sel  out  1 each  regfile write, memory write, load-address select
- dmem_ctrl  out  3  funct3 for load/store
- branch_ctrl  out  3  funct3 for branch
- jump_en  out  1  branch/JAL/JALR
- jump_type  out  2  00 none, 01 branch, 10 JAL, 11 JALR
- imm  out  XLEN  sign-extended immediate
- jump_offset  out  XLEN  B- or J-type offset
- illegal  out  1  undecodable opcode

Behaviour:
- Reset (synchronous, highest priority): all outputs 0; out_valid=0; bubble counter=0; load tracker cleared.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- Output register loads when (!out_valid || out_ready). Holds stable while out_valid && !out_ready.
- in_ready = (!out_valid || out_ready) && !flush && state==RUN && !hazard.
- Fields are zero for unused classes. No Z values anywhere.
- rs1:
  - valid for R, I-ALU, load, store, branch, custom, JALR;
  - 0 for LUI, AUIPC, JAL.
- rs2: R, store, branch only.
- rd: R, I-ALU, load, LUI, AUIPC, JAL, JALR.
- imm by format:
  - I-type for I-ALU, load, JALR;
  - S-type for store;
  - U-type ({inst[31:12],12'b0}, sign-extended to XLEN) for LUI/AUIPC.
  - All sign-extend from inst[31].
- jump_offset: B-type for branch, J-type ({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, sign-extended) for JAL; else 0.
- alu_ctrl:
  - R: {inst[30],funct3};
  - I-ALU: {inst[30] && funct3==3'b101, funct3};
  - load/store/JALR/AUIPC: 4'b0000 (add);
  - LUI: 4'b0000, with rs1=0.
- op1_sel=1 for I-ALU, load, store, LUI, AUIPC, JALR.
- w_en=1 for R, I-ALU, load, LUI, AUIPC, JAL, JALR, but forced 0 when rd==0.
- mw_en=1 for store. maddr_sel=1 for load.
- State machine: RUN and BUBBLE.
  - Load tracker records rd and a load flag for every accepted load with rd!=0.
  - hazard = tracker flag && in_valid && tracked rd equals a used rs1/rs2 of in_inst && LOAD_USE_BUBBLES>0.
  - In RUN with hazard and free output slot: go to BUBBLE, count=LOAD_USE_BUBBLES, out_valid=0, clear tracker.
  - BUBBLE: in_ready=0; count decrements each cycle; at 0 return to RUN.
  - Accepting a non-load, or a load with rd=0, clears the tracker.
- Flush: synchronous, overrides handshake. Next cycle out_valid=0, state=RUN, tracker cleared, in_inst not accepted. Flush during BUBBLE aborts the bubble.
- Simultaneous out_ready and accept: the new bundle replaces the old one the same edge, with no gap.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: unrecognised opcode or inst[1:0]!=2'b11 sets illegal=1 with the bundle. All enables (w_en, mw_en, jump_en) are forced 0. rs/rd/imm are 0.
- Undefined: illegal port tied 0; such instructions decode as NOP (all fields 0) and still flow as valid bundles.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_ctrl=0000, w_en=1, op1_sel=0.
- LW x5,8(x1) then ADD x6,x5,x0, LOAD_USE_BUBBLES=1 -> LW out, one cycle out_valid=0 with in_ready=0, then ADD out.
- JAL x1,-4 (0xFFDFF0EF) -> jump_type=10, jump_en=1, rd=1, w_en=1, jump_offset=0xFFFFFFFC.
- out_ready=0 for 3 cycles while out_valid=1 with ADDI -> bundle held constant, in_ready=0. Release -> next instruction follows without gap.
- Flush asserted in BUBBLE state and with a valid held bundle -> next cycle out_valid=0, state RUN, in_ready=1.
- With DECODE_ILLEGAL_TRAP_EN, in_inst=0x00000000 -> illegal=1, w_en=mw_en=jump_en=0. Without the macro -> illegal=0, all fields 0.
